hyper_lsab_dram_multi: RTL and testbench

Parametrised LSAB↔DRAM transfer controller between the hyper scheduler and the block mover / MCU alignment logic. It generalises address, page and block-length widths and supports N DRAMs with per-DRAM align request/grant. It adds an optional automatic page-crossing mode: one command is split into several block-mover issues, and completion is reported once.

---
 rtl/hyper_lsab_pkg.sv | 25 ++
 rtl/hyper_lsab_chunk_calc.sv | 26 ++
 rtl/hyper_lsab_dram_multi.sv | 227 ++++++++++++++++++++++
 tb/tb_hyper_lsab_dram_multi.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_lsab_pkg.sv
// Shared types and defaults for the LSAB<->DRAM transfer controller.
// Provides the FSM state encoding and the DRAM-select width helper.
package hyper_lsab_pkg;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefPageW = 12;
    localparam int unsigned DefLenW  = 6;
    localparam int unsigned DefSectW = 2;
    localparam int unsigned DefNDram = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCalc,
        StIssue,
        StRun,
        StCross
    } state_e;

    // A single DRAM still gets a 1-bit select so the port never collapses to zero width.
    function automatic int unsigned dsel_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hyper_lsab_chunk_calc.sv
// Splits the remaining transfer at the page boundary: returns the chunk
// length for this page and whether the request reaches the page end.
module hyper_lsab_chunk_calc
    import hyper_lsab_pkg::*;
#(
    parameter int unsigned PAGE_W = DefPageW,
    parameter int unsigned LEN_W  = DefLenW
) (
    input  logic [PAGE_W-1:0] start_i,
    input  logic [LEN_W-1:0]  remaining_i,
    output logic [LEN_W-1:0]  chunk_o,
    output logic              page_end_o
);

    logic [PAGE_W:0] end_sum;
    logic [PAGE_W:0] page_left;

    always_comb begin
        end_sum    = {1'b0, start_i} + (PAGE_W+1)'(remaining_i);
        page_left  = {1'b1, {PAGE_W{1'b0}}} - {1'b0, start_i};
        page_end_o = end_sum[PAGE_W];
        // page_left only matters when remaining >= page_left, so it fits in LEN_W
        chunk_o    = page_end_o ? LEN_W'(page_left) : remaining_i;
    end

endmodule

// File: rtl/hyper_lsab_dram_multi.sv
// LSAB<->DRAM transfer controller: aligns the target DRAM, issues block-mover
// chunks (optionally crossing pages) and reports a single completion.
module hyper_lsab_dram_multi
    import hyper_lsab_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned PAGE_W   = DefPageW,
    parameter int unsigned LEN_W    = DefLenW,
    parameter int unsigned SECT_W   = DefSectW,
    parameter int unsigned N_DRAM   = DefNDram,
    localparam int unsigned DSEL_W  = dsel_w(N_DRAM)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     GO,
    input  logic [LEN_W-1:0]         BLOCK_LENGTH,
    input  logic [ADDR_W-1:0]        NEW_ADDR,
    input  logic [SECT_W-1:0]        NEW_SECTION,
    input  logic [DSEL_W-1:0]        NEW_DRAM,
    input  logic                     AUTO_CROSS,
    output logic                     READY,
    output logic [ADDR_W-1:0]        OLD_ADDR,
    output logic                     ENDOF_PAGE,
    output logic [LEN_W-1:0]         COUNT_SENT,
    output logic [PAGE_W-1:0]        BLCK_START,
    output logic [LEN_W-1:0]         BLCK_COUNT_REQ,
    output logic                     BLCK_ISSUE,
    output logic [SECT_W-1:0]        BLCK_SECTION,
    input  logic [LEN_W-1:0]         BLCK_COUNT_SENT,
    input  logic                     BLCK_WORKING,
    output logic [ADDR_W-PAGE_W-1:0] MCU_PAGE_ADDR,
    output logic [N_DRAM-1:0]        MCU_REQUEST_ALIGN,
    input  logic [N_DRAM-1:0]        MCU_GRANT_ALIGN
);

    localparam int unsigned PG_W = ADDR_W - PAGE_W;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [SECT_W-1:0]   cmd_sect_q, cmd_sect_d;
    logic [DSEL_W-1:0]   cmd_dram_q, cmd_dram_d;
    logic                cmd_auto_q, cmd_auto_d;
    logic [PG_W-1:0]     page_q, page_d;
    logic [PAGE_W-1:0]   start_q, start_d;
    logic [SECT_W-1:0]   sect_q, sect_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [LEN_W-1:0]    total_q, total_d;
    logic [LEN_W-1:0]    count_req_q, count_req_d;
    logic                end_bit_q, end_bit_d;
    logic [N_DRAM-1:0]   req_q, req_d;
    logic [ADDR_W-1:0]   old_addr_q, old_addr_d;
    logic [LEN_W-1:0]    count_sent_q, count_sent_d;
    logic                eop_q, eop_d;
    logic                working_q;

    logic [LEN_W-1:0]    chunk_len;
    logic                chunk_end;
    logic [N_DRAM-1:0]   dram_onehot;
    logic                grant_ok;
    logic                fall;
    logic                complete;
    logic [LEN_W-1:0]    rem_after;
    logic [LEN_W-1:0]    total_after;
    logic [ADDR_W-1:0]   sent_addr;
    logic                issue;

    hyper_lsab_chunk_calc #(
        .PAGE_W (PAGE_W),
        .LEN_W  (LEN_W)
    ) u_chunk_calc (
        .start_i     (start_q),
        .remaining_i (remaining_q),
        .chunk_o     (chunk_len),
        .page_end_o  (chunk_end)
    );

    always_comb begin
        dram_onehot = N_DRAM'(1) << cmd_dram_q;
        grant_ok    = |(MCU_GRANT_ALIGN & dram_onehot);
        fall        = working_q & ~BLCK_WORKING;
        complete    = (BLCK_COUNT_SENT >= count_req_q);
        rem_after   = remaining_q - BLCK_COUNT_SENT;
        total_after = total_q + BLCK_COUNT_SENT;
        sent_addr   = {page_q, start_q} + ADDR_W'(BLCK_COUNT_SENT);
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_sect_d   = cmd_sect_q;
        cmd_dram_d   = cmd_dram_q;
        cmd_auto_d   = cmd_auto_q;
        page_d       = page_q;
        start_d      = start_q;
        sect_d       = sect_q;
        remaining_d  = remaining_q;
        total_d      = total_q;
        count_req_d  = count_req_q;
        end_bit_d    = end_bit_q;
        req_d        = req_q;
        old_addr_d   = old_addr_q;
        count_sent_d = count_sent_q;
        eop_d        = eop_q;
        issue        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (GO) begin
                    len_d      = BLOCK_LENGTH;
                    cmd_addr_d = NEW_ADDR;
                    cmd_sect_d = NEW_SECTION;
                    cmd_dram_d = NEW_DRAM;
                    cmd_auto_d = AUTO_CROSS;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                page_d      = cmd_addr_q[ADDR_W-1:PAGE_W];
                start_d     = cmd_addr_q[PAGE_W-1:0];
                sect_d      = cmd_sect_q;
                remaining_d = len_q;
                total_d     = '0;
                if (len_q == '0) begin
                    old_addr_d   = cmd_addr_q;
                    count_sent_d = '0;
                    eop_d        = 1'b0;
                    state_d      = StIdle;
                end else begin
                    req_d   = dram_onehot;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                count_req_d = chunk_len;
                end_bit_d   = chunk_end;
                state_d     = StIssue;
            end
            StIssue: begin
                // working_q guards against a mover that has only just dropped busy
                if (grant_ok && !BLCK_WORKING && !working_q) begin
                    issue   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (fall) begin
                    total_d     = total_after;
                    remaining_d = rem_after;
                    req_d       = '0;
                    if (complete && end_bit_q && (rem_after != '0) && cmd_auto_q) begin
                        state_d = StCross;
                    end else begin
                        old_addr_d   = sent_addr;
                        count_sent_d = total_after;
                        eop_d        = complete && end_bit_q;
                        state_d      = StIdle;
                    end
                end
            end
            StCross: begin
                page_d  = page_q + PG_W'(1);
                start_d = '0;
                req_d   = dram_onehot;
                state_d = StCalc;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            len_q        <= '0;
            cmd_addr_q   <= '0;
            cmd_sect_q   <= '0;
            cmd_dram_q   <= '0;
            cmd_auto_q   <= 1'b0;
            page_q       <= '0;
            start_q      <= '0;
            sect_q       <= '0;
            remaining_q  <= '0;
            total_q      <= '0;
            count_req_q  <= '0;
            end_bit_q    <= 1'b0;
            req_q        <= '0;
            old_addr_q   <= '0;
            count_sent_q <= '0;
            eop_q        <= 1'b0;
            working_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_sect_q   <= cmd_sect_d;
            cmd_dram_q   <= cmd_dram_d;
            cmd_auto_q   <= cmd_auto_d;
            page_q       <= page_d;
            start_q      <= start_d;
            sect_q       <= sect_d;
            remaining_q  <= remaining_d;
            total_q      <= total_d;
            count_req_q  <= count_req_d;
            end_bit_q    <= end_bit_d;
            req_q        <= req_d;
            old_addr_q   <= old_addr_d;
            count_sent_q <= count_sent_d;
            eop_q        <= eop_d;
            working_q    <= BLCK_WORKING;
        end
    end

    always_comb begin
        READY             = (state_q == StIdle);
        BLCK_ISSUE        = issue;
        OLD_ADDR          = old_addr_q;
        ENDOF_PAGE        = eop_q;
        COUNT_SENT        = count_sent_q;
        BLCK_START        = start_q;
        BLCK_COUNT_REQ    = count_req_q;
        BLCK_SECTION      = sect_q;
        MCU_PAGE_ADDR     = page_q;
        MCU_REQUEST_ALIGN = req_q;
    end

endmodule

// File: tb/tb_hyper_lsab_dram_multi.sv
// Scoreboard bench for hyper_lsab_dram_multi: stimulus queues expected issues
// and completions; independent monitors pop and compare them.
module tb_hyper_lsab_dram_multi;

    logic        CLK;
    logic        RST;
    logic        GO;
    logic [5:0]  BLOCK_LENGTH;
    logic [31:0] NEW_ADDR;
    logic [1:0]  NEW_SECTION;
    logic [0:0]  NEW_DRAM;
    logic        AUTO_CROSS;
    logic        READY;
    logic [31:0] OLD_ADDR;
    logic        ENDOF_PAGE;
    logic [5:0]  COUNT_SENT;
    logic [11:0] BLCK_START;
    logic [5:0]  BLCK_COUNT_REQ;
    logic        BLCK_ISSUE;
    logic [1:0]  BLCK_SECTION;
    logic [5:0]  BLCK_COUNT_SENT;
    logic        BLCK_WORKING;
    logic [19:0] MCU_PAGE_ADDR;
    logic [1:0]  MCU_REQUEST_ALIGN;
    logic [1:0]  MCU_GRANT_ALIGN;

    hyper_lsab_dram_multi #(
        .ADDR_W (32),
        .PAGE_W (12),
        .LEN_W  (6),
        .SECT_W (2),
        .N_DRAM (2)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .GO                (GO),
        .BLOCK_LENGTH      (BLOCK_LENGTH),
        .NEW_ADDR          (NEW_ADDR),
        .NEW_SECTION       (NEW_SECTION),
        .NEW_DRAM          (NEW_DRAM),
        .AUTO_CROSS        (AUTO_CROSS),
        .READY             (READY),
        .OLD_ADDR          (OLD_ADDR),
        .ENDOF_PAGE        (ENDOF_PAGE),
        .COUNT_SENT        (COUNT_SENT),
        .BLCK_START        (BLCK_START),
        .BLCK_COUNT_REQ    (BLCK_COUNT_REQ),
        .BLCK_ISSUE        (BLCK_ISSUE),
        .BLCK_SECTION      (BLCK_SECTION),
        .BLCK_COUNT_SENT   (BLCK_COUNT_SENT),
        .BLCK_WORKING      (BLCK_WORKING),
        .MCU_PAGE_ADDR     (MCU_PAGE_ADDR),
        .MCU_REQUEST_ALIGN (MCU_REQUEST_ALIGN),
        .MCU_GRANT_ALIGN   (MCU_GRANT_ALIGN)
    );

    typedef struct {
        logic [11:0] start;
        logic [5:0]  req;
        logic [19:0] page;
        logic [1:0]  align;
    } iss_t;

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  cnt;
        logic        eop;
    } res_t;

    iss_t iss_q[$];
    res_t res_q[$];
    int   total;
    int   bad;
    int   mover_limit;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic exp_iss(input logic [11:0] s, input logic [5:0] r, input logic [19:0] p,
                           input logic [1:0] a);
        iss_t e;
        e = '{start: s, req: r, page: p, align: a};
        iss_q.push_back(e);
    endtask

    task automatic exp_res(input logic [31:0] a, input logic [5:0] c, input logic e);
        res_t r;
        r = '{addr: a, cnt: c, eop: e};
        res_q.push_back(r);
    endtask

    // Caller is in a READY cycle; returns one cycle later with GO dropped.
    task automatic send_cmd(input logic [5:0] len, input logic [31:0] addr, input logic [1:0] sect,
                            input logic dram, input logic auto_x);
        GO           = 1'b1;
        BLOCK_LENGTH = len;
        NEW_ADDR     = addr;
        NEW_SECTION  = sect;
        NEW_DRAM     = dram;
        AUTO_CROSS   = auto_x;
        tick();
        GO           = 1'b0;
    endtask

    task automatic wait_ready(input int budget, input string name);
        int n;
        n = 0;
        while (READY !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(name, READY, 1);
    endtask

    // Block mover model: busy for three cycles, then reports min(request, limit).
    initial begin : mover
        int n;
        BLCK_WORKING    = 1'b0;
        BLCK_COUNT_SENT = '0;
        forever begin
            @(negedge CLK);
            if (BLCK_ISSUE === 1'b1 && RST === 1'b0) begin
                n = int'(BLCK_COUNT_REQ);
                if (n > mover_limit) n = mover_limit;
                @(posedge CLK);
                #2 BLCK_WORKING = 1'b1;
                repeat (3) @(posedge CLK);
                #2;
                BLCK_COUNT_SENT = 6'(n);
                BLCK_WORKING    = 1'b0;
            end
        end
    end

    initial begin : iss_mon
        logic iss_prev;
        iss_t e;
        iss_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (BLCK_ISSUE === 1'b1) begin
                chk("iss_pending", iss_q.size() != 0, 1);
                chk("iss_while_busy", BLCK_WORKING, 0);
                chk("iss_back_to_back", iss_prev, 0);
                if (iss_q.size() != 0) begin
                    e = iss_q.pop_front();
                    chk("iss_start", BLCK_START, e.start);
                    chk("iss_count_req", BLCK_COUNT_REQ, e.req);
                    chk("iss_page", MCU_PAGE_ADDR, e.page);
                    chk("iss_align", MCU_REQUEST_ALIGN, e.align);
                end
            end
            iss_prev = BLCK_ISSUE;
        end
    end

    initial begin : res_mon
        logic rdy_prev;
        logic rst_prev;
        res_t r;
        rdy_prev = 1'b1;
        rst_prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (rdy_prev === 1'b0 && READY === 1'b1 && rst_prev === 1'b0) begin
                chk("res_pending", res_q.size() != 0, 1);
                if (res_q.size() != 0) begin
                    r = res_q.pop_front();
                    chk("res_old_addr", OLD_ADDR, r.addr);
                    chk("res_count_sent", COUNT_SENT, r.cnt);
                    chk("res_endof_page", ENDOF_PAGE, r.eop);
                end
            end
            rdy_prev = READY;
            rst_prev = RST;
        end
    end

    initial begin : stim
        int lows;
        int falls;
        int n;
        logic prev_nz;
        total = 0;
        bad   = 0;
        RST             = 1'b1;
        GO              = 1'b0;
        BLOCK_LENGTH    = '0;
        NEW_ADDR        = '0;
        NEW_SECTION     = '0;
        NEW_DRAM        = '0;
        AUTO_CROSS      = 1'b0;
        MCU_GRANT_ALIGN = 2'b11;
        mover_limit     = 63;

        repeat (3) tick();
        #1;
        chk("rst_ready", READY, 1);
        chk("rst_issue", BLCK_ISSUE, 0);
        chk("rst_req", MCU_REQUEST_ALIGN, 0);
        chk("rst_old_addr", OLD_ADDR, 0);
        chk("rst_count_sent", COUNT_SENT, 0);
        chk("rst_eop", ENDOF_PAGE, 0);
        chk("rst_count_req", BLCK_COUNT_REQ, 0);
        RST = 1'b0;
        tick();

        // 1: in-page transfer with timing checks
        exp_iss(12'h100, 6'd32, 20'h00010, 2'b01);
        exp_res(32'h00010120, 6'd32, 1'b0);
        send_cmd(6'd32, 32'h00010100, 2'd1, 1'b0, 1'b0);
        #1 chk("t1_ready_low", READY, 0);
        tick();
        tick();
        #1;
        chk("t1_issue_at_t3", BLCK_ISSUE, 1);
        chk("t1_section", BLCK_SECTION, 1);
        wait_ready(60, "t1_done");

        // 2: boundary, no cross
        exp_iss(12'hFF0, 6'd16, 20'h00010, 2'b01);
        exp_res(32'h00011000, 6'd16, 1'b1);
        send_cmd(6'd63, 32'h00010FF0, 2'd0, 1'b0, 1'b0);
        wait_ready(60, "t2_done");

        // 3: auto-cross, request low for exactly one cycle between chunks
        exp_iss(12'hFF0, 6'd16, 20'h00010, 2'b01);
        exp_iss(12'h000, 6'd47, 20'h00011, 2'b01);
        exp_res(32'h0001102F, 6'd63, 1'b0);
        send_cmd(6'd63, 32'h00010FF0, 2'd0, 1'b0, 1'b1);
        lows    = 0;
        falls   = 0;
        prev_nz = 1'b0;
        n       = 0;
        while (n < 200) begin
            @(negedge CLK);
            if (READY === 1'b1) break;
            if (MCU_REQUEST_ALIGN == 2'b00) begin
                lows++;
                if (prev_nz) falls++;
            end
            prev_nz = (MCU_REQUEST_ALIGN != 2'b00);
            n++;
        end
        chk("t3_done", READY, 1);
        chk("t3_req_low_cycles", lows, 2);
        chk("t3_req_drops", falls, 1);
        tick();

        // 4: short chunk
        mover_limit = 25;
        exp_iss(12'h200, 6'd40, 20'h00020, 2'b01);
        exp_res(32'h00020219, 6'd25, 1'b0);
        send_cmd(6'd40, 32'h00020200, 2'd2, 1'b0, 1'b1);
        wait_ready(60, "t4_done");
        mover_limit = 63;

        // 5: second DRAM, grant withheld for ten cycles
        MCU_GRANT_ALIGN = 2'b01;
        exp_iss(12'h000, 6'd8, 20'h00030, 2'b10);
        exp_res(32'h00030008, 6'd8, 1'b0);
        send_cmd(6'd8, 32'h00030000, 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("t5_req_onehot", MCU_REQUEST_ALIGN, 2'b10);
            chk("t5_no_issue", BLCK_ISSUE, 0);
        end
        tick();
        MCU_GRANT_ALIGN = 2'b11;
        #1 chk("t5_issue_on_grant", BLCK_ISSUE, 1);
        wait_ready(60, "t5_done");

        // 6a: zero length returns to READY at t+2
        exp_res(32'h00040040, 6'd0, 1'b0);
        send_cmd(6'd0, 32'h00040040, 2'd0, 1'b0, 1'b0);
        #1 chk("t6a_busy_t1", READY, 0);
        tick();
        #1 chk("t6a_ready_t2", READY, 1);
        tick();

        // 6b: GO while busy is ignored
        exp_iss(12'h000, 6'd16, 20'h00050, 2'b01);
        exp_res(32'h00050010, 6'd16, 1'b0);
        send_cmd(6'd16, 32'h00050000, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        GO           = 1'b1;
        BLOCK_LENGTH = 6'd5;
        NEW_ADDR     = 32'h00099990;
        tick();
        GO = 1'b0;
        wait_ready(60, "t6b_done");
        tick();
        tick();
        #1 chk("t6b_stays_idle", READY, 1);
        tick();

        // 6c: reset during RUN
        exp_iss(12'h000, 6'd20, 20'h00060, 2'b01);
        send_cmd(6'd20, 32'h00060000, 2'd2, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        RST = 1'b1;
        tick();
        #1;
        chk("t6c_ready", READY, 1);
        chk("t6c_issue", BLCK_ISSUE, 0);
        chk("t6c_req", MCU_REQUEST_ALIGN, 0);
        chk("t6c_old_addr", OLD_ADDR, 0);
        chk("t6c_count_sent", COUNT_SENT, 0);
        chk("t6c_eop", ENDOF_PAGE, 0);
        chk("t6c_start", BLCK_START, 0);
        chk("t6c_count_req", BLCK_COUNT_REQ, 0);
        chk("t6c_page", MCU_PAGE_ADDR, 0);
        chk("t6c_section", BLCK_SECTION, 0);
        RST = 1'b0;
        repeat (8) tick();

        chk("iss_q_drained", iss_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
